// File: rtl/bibp_yanitlayici.sv
// bibp instruction responder: valid/ready in, iterative ALU, valid/ready out; BIBP_YANIT_SAYAC_EN adds islem_sayisi.
// Latency 1 (add/sub/max), U (mul/div/mod), max(1,min(b,U)) (shifts); result held while sonuc_hazir is low.
module bibp_yanitlayici #(
  parameter int UZUNLUK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*UZUNLUK+2:0] buyruk,
  input  logic                 buyruk_gecerli,
  output logic                 buyruk_hazir,
  output logic [UZUNLUK:0]     sonuc,
  output logic                 sonuc_gecerli,
  input  logic                 sonuc_hazir,
  output logic                 mesgul
`ifdef BIBP_YANIT_SAYAC_EN
  ,
  output logic [15:0]          islem_sayisi
`endif
);

  localparam int U  = UZUNLUK;
  localparam int SW = $clog2(UZUNLUK + 1);
  localparam logic [SW-1:0] S_BIR = SW'(1);
  localparam logic [SW-1:0] S_U   = SW'(UZUNLUK);
  localparam logic [U-1:0]  V_U   = U'(UZUNLUK);
  localparam logic [U-1:0]  V_BIR = U'(1);

  localparam logic [2:0] OP_TOPLA = 3'b000;
  localparam logic [2:0] OP_CIKAR = 3'b001;
  localparam logic [2:0] OP_SOLA  = 3'b010;
  localparam logic [2:0] OP_SAGA  = 3'b011;
  localparam logic [2:0] OP_CARP  = 3'b100;
  localparam logic [2:0] OP_BOL   = 3'b101;
  localparam logic [2:0] OP_MOD   = 3'b110;
  localparam logic [2:0] OP_MAKS  = 3'b111;

  typedef enum logic [1:0] {BOSTA, HESAPLA, SONUC} durum_t;

  durum_t         durum_q, durum_d;
  logic [2:0]     islem_q, islem_d;
  logic [U-1:0]   a_q, a_d, b_q, b_d;
  logic [SW-1:0]  sayac_q, sayac_d;
  logic [U-1:0]   kaydir_q, kaydir_d;
  logic [2*U-1:0] carp_q, carp_d, eklenen_q, eklenen_d;
  logic [U:0]     kalan_q, kalan_d;
  logic           bayrak_q, bayrak_d;
  logic [U:0]     sonuc_q, sonuc_d;
  logic           sonuc_gecerli_q, sonuc_gecerli_d;
  logic           mesgul_q, mesgul_d;
`ifdef BIBP_YANIT_SAYAC_EN
  logic [15:0]    islem_sayisi_q, islem_sayisi_d;
`endif

  logic [2:0]     yeni_islem;
  logic [U-1:0]   yeni_a, yeni_b, kay_say;
  logic [U:0]     toplam, fark, kal_kay, kal_fark, kalan_yeni;
  logic [2*U-1:0] carp_yeni;
  logic [U-1:0]   sonraki_kay;
  logic           sonraki_bayrak;

  always_comb begin
    durum_d         = durum_q;
    islem_d         = islem_q;
    a_d             = a_q;
    b_d             = b_q;
    sayac_d         = sayac_q;
    kaydir_d        = kaydir_q;
    carp_d          = carp_q;
    eklenen_d       = eklenen_q;
    kalan_d         = kalan_q;
    bayrak_d        = bayrak_q;
    sonuc_d         = sonuc_q;
    sonuc_gecerli_d = sonuc_gecerli_q;
    mesgul_d        = mesgul_q;
`ifdef BIBP_YANIT_SAYAC_EN
    islem_sayisi_d  = islem_sayisi_q;
`endif

    yeni_islem = buyruk[2*U+2:2*U];
    yeni_a     = buyruk[2*U-1:U];
    yeni_b     = buyruk[U-1:0];
    kay_say    = (yeni_b > V_U) ? V_U : yeni_b;

    // One-step datapath; each op only consumes the parts that belong to it.
    toplam     = {1'b0, a_q} + {1'b0, b_q};
    fark       = {1'b0, a_q} - {1'b0, b_q};
    kal_kay    = {kalan_q[U-1:0], kaydir_q[U-1]};
    kal_fark   = kal_kay - {1'b0, b_q};
    kalan_yeni = (kal_kay >= {1'b0, b_q}) ? kal_fark : kal_kay;
    carp_yeni  = carp_q + (kaydir_q[0] ? eklenen_q : '0);

    sonraki_kay    = kaydir_q;
    sonraki_bayrak = bayrak_q;
    case (islem_q)
      OP_SOLA: if (b_q != '0) begin
        sonraki_kay    = kaydir_q << 1;
        sonraki_bayrak = bayrak_q | kaydir_q[U-1];
      end
      OP_SAGA: if (b_q != '0) begin
        sonraki_kay    = kaydir_q >> 1;
        sonraki_bayrak = bayrak_q | kaydir_q[0];
      end
      OP_CARP: sonraki_kay = kaydir_q >> 1;
      OP_BOL, OP_MOD:
        sonraki_kay = (kal_kay >= {1'b0, b_q}) ? ((kaydir_q << 1) | V_BIR) : (kaydir_q << 1);
      default: ;
    endcase

    case (durum_q)
      BOSTA: begin
        if (buyruk_gecerli) begin
          islem_d   = yeni_islem;
          a_d       = yeni_a;
          b_d       = yeni_b;
          kaydir_d  = (yeni_islem == OP_CARP) ? yeni_b : yeni_a;
          carp_d    = '0;
          eklenen_d = {{U{1'b0}}, yeni_a};
          kalan_d   = '0;
          bayrak_d  = 1'b0;
          durum_d   = HESAPLA;
          mesgul_d  = 1'b1;
          case (yeni_islem)
            OP_TOPLA, OP_CIKAR, OP_MAKS: sayac_d = S_BIR;
            OP_SOLA, OP_SAGA:            sayac_d = (kay_say == '0) ? S_BIR : SW'(kay_say);
            default:                     sayac_d = S_U;
          endcase
        end
      end
      HESAPLA: begin
        kaydir_d  = sonraki_kay;
        bayrak_d  = sonraki_bayrak;
        carp_d    = carp_yeni;
        eklenen_d = eklenen_q << 1;
        kalan_d   = kalan_yeni;
        sayac_d   = sayac_q - S_BIR;
        if (sayac_q == S_BIR) begin
          durum_d         = SONUC;
          sonuc_gecerli_d = 1'b1;
          case (islem_q)
            OP_TOPLA:         sonuc_d = toplam;
            OP_CIKAR:         sonuc_d = fark;
            OP_SOLA, OP_SAGA: sonuc_d = {sonraki_bayrak, sonraki_kay};
            OP_CARP:          sonuc_d = {|carp_yeni[2*U-1:U], carp_yeni[U-1:0]};
            OP_BOL:           sonuc_d = (b_q == '0) ? '1 : {1'b0, sonraki_kay};
            OP_MOD:           sonuc_d = (b_q == '0) ? {1'b1, a_q} : {1'b0, kalan_yeni[U-1:0]};
            default:          sonuc_d = {a_q == b_q, (a_q >= b_q) ? a_q : b_q};
          endcase
        end
      end
      SONUC: begin
        if (sonuc_hazir) begin
          durum_d         = BOSTA;
          sonuc_gecerli_d = 1'b0;
          mesgul_d        = 1'b0;
`ifdef BIBP_YANIT_SAYAC_EN
          islem_sayisi_d  = islem_sayisi_q + 16'd1;
`endif
        end
      end
      default: begin
        durum_d         = BOSTA;
        sonuc_gecerli_d = 1'b0;
        mesgul_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q         <= BOSTA;
      islem_q         <= '0;
      a_q             <= '0;
      b_q             <= '0;
      sayac_q         <= '0;
      kaydir_q        <= '0;
      carp_q          <= '0;
      eklenen_q       <= '0;
      kalan_q         <= '0;
      bayrak_q        <= 1'b0;
      sonuc_q         <= '0;
      sonuc_gecerli_q <= 1'b0;
      mesgul_q        <= 1'b0;
`ifdef BIBP_YANIT_SAYAC_EN
      islem_sayisi_q  <= '0;
`endif
    end else begin
      durum_q         <= durum_d;
      islem_q         <= islem_d;
      a_q             <= a_d;
      b_q             <= b_d;
      sayac_q         <= sayac_d;
      kaydir_q        <= kaydir_d;
      carp_q          <= carp_d;
      eklenen_q       <= eklenen_d;
      kalan_q         <= kalan_d;
      bayrak_q        <= bayrak_d;
      sonuc_q         <= sonuc_d;
      sonuc_gecerli_q <= sonuc_gecerli_d;
      mesgul_q        <= mesgul_d;
`ifdef BIBP_YANIT_SAYAC_EN
      islem_sayisi_q  <= islem_sayisi_d;
`endif
    end
  end

  assign buyruk_hazir  = (durum_q == BOSTA);
  assign sonuc         = sonuc_q;
  assign sonuc_gecerli = sonuc_gecerli_q;
  assign mesgul        = mesgul_q;
`ifdef BIBP_YANIT_SAYAC_EN
  assign islem_sayisi  = islem_sayisi_q;
`endif

endmodule

// File: tb/tb_bibp_yanitlayici.sv
// Directed bench for bibp_yanitlayici (UZUNLUK=4); hand-computed results and latencies.
module tb_bibp_yanitlayici;

  logic        clk;
  logic        rst_n;
  logic [10:0] buyruk;
  logic        buyruk_gecerli;
  logic        buyruk_hazir;
  logic [4:0]  sonuc;
  logic        sonuc_gecerli;
  logic        sonuc_hazir;
  logic        mesgul;
`ifdef BIBP_YANIT_SAYAC_EN
  logic [15:0] islem_sayisi;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_exp = 0;

  bibp_yanitlayici #(.UZUNLUK(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .buyruk         (buyruk),
    .buyruk_gecerli (buyruk_gecerli),
    .buyruk_hazir   (buyruk_hazir),
    .sonuc          (sonuc),
    .sonuc_gecerli  (sonuc_gecerli),
    .sonuc_hazir    (sonuc_hazir),
    .mesgul         (mesgul)
`ifdef BIBP_YANIT_SAYAC_EN
    ,
    .islem_sayisi   (islem_sayisi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one instruction, measure latency, check the result, then complete the handshake.
  task automatic run(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                     input int n_exp, input logic [4:0] r_exp);
    int cyc;
    @(negedge clk);
    chk({tag, " hazir"}, buyruk_hazir, 1);
    buyruk = {op, a, b};
    buyruk_gecerli = 1'b1;
    @(posedge clk);
    @(negedge clk);
    buyruk_gecerli = 1'b0;
    buyruk = ~buyruk;
    cyc = 0;
    while (sonuc_gecerli !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, n_exp);
    chk({tag, " sonuc"}, sonuc, r_exp);
    sonuc_hazir = 1'b1;
    @(negedge clk);
    sonuc_hazir = 1'b0;
    cnt_exp++;
    chk({tag, " done"}, {buyruk_hazir, sonuc_gecerli, mesgul}, 3'b100);
    chk({tag, " held"}, sonuc, r_exp);
`ifdef BIBP_YANIT_SAYAC_EN
    chk({tag, " sayac"}, islem_sayisi, cnt_exp);
`endif
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    buyruk = '0;
    buyruk_gecerli = 1'b0;
    sonuc_hazir = 1'b0;
    #1;
    chk("reset sonuc", sonuc, 0);
    chk("reset flags", {buyruk_hazir, sonuc_gecerli, mesgul}, 3'b100);
`ifdef BIBP_YANIT_SAYAC_EN
    chk("reset sayac", islem_sayisi, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run("add 9+8", 3'b000, 4'd9, 4'd8, 1, 5'b10001);

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    buyruk = {3'b100, 4'd7, 4'd3};
    buyruk_gecerli = 1'b1;
    @(posedge clk);
    @(negedge clk);
    buyruk_gecerli = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midmul busy", {buyruk_hazir, sonuc_gecerli, mesgul}, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("midmul rst sonuc", sonuc, 0);
    chk("midmul rst flags", {buyruk_hazir, sonuc_gecerli, mesgul}, 3'b100);
    cnt_exp = 0;
`ifdef BIBP_YANIT_SAYAC_EN
    chk("midmul rst sayac", islem_sayisi, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run("add 2+3",   3'b000, 4'd2,     4'd3,     1, 5'b00101);
    run("sub 3-5",   3'b001, 4'd3,     4'd5,     1, 5'b11110);
    run("mul 7*3",   3'b100, 4'd7,     4'd3,     4, 5'b10101);
    run("mul 3*5",   3'b100, 4'd3,     4'd5,     4, 5'b01111);
    run("div 13/4",  3'b101, 4'd13,    4'd4,     4, 5'b00011);
    run("mod 13%4",  3'b110, 4'd13,    4'd4,     4, 5'b00001);
    run("div 13/0",  3'b101, 4'd13,    4'd0,     4, 5'b11111);
    run("mod 13%0",  3'b110, 4'd13,    4'd0,     4, 5'b11101);
    run("shl b<<2",  3'b010, 4'b1011,  4'd2,     2, 5'b11100);
    run("shr b>>9",  3'b011, 4'b1011,  4'd9,     4, 5'b10000);
    run("shl b<<0",  3'b010, 4'b1011,  4'd0,     1, 5'b01011);
    run("shr 8>>1",  3'b011, 4'b1000,  4'd1,     1, 5'b00100);
    run("max 6,6",   3'b111, 4'd6,     4'd6,     1, 5'b10110);
    run("max 2,9",   3'b111, 4'd2,     4'd9,     1, 5'b01001);

    // Backpressure: result held, input ignored while the consumer stalls.
    @(negedge clk);
    buyruk = {3'b000, 4'd1, 4'd1};
    buyruk_gecerli = 1'b1;
    @(posedge clk);
    @(negedge clk);
    buyruk_gecerli = 1'b0;
    cyc = 0;
    while (sonuc_gecerli !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp latency", cyc, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp sonuc", sonuc, 5'b00010);
      chk("bp flags", {buyruk_hazir, sonuc_gecerli, mesgul}, 3'b011);
      if (i == 2) begin
        buyruk = {3'b000, 4'd15, 4'd15};
        buyruk_gecerli = 1'b1;
      end else begin
        buyruk_gecerli = 1'b0;
      end
      @(negedge clk);
    end
    buyruk_gecerli = 1'b0;
`ifdef BIBP_YANIT_SAYAC_EN
    chk("bp sayac before", islem_sayisi, cnt_exp);
`endif
    sonuc_hazir = 1'b1;
    @(negedge clk);
    sonuc_hazir = 1'b0;
    cnt_exp++;
    chk("bp release flags", {buyruk_hazir, sonuc_gecerli, mesgul}, 3'b100);
    chk("bp release sonuc", sonuc, 5'b00010);
`ifdef BIBP_YANIT_SAYAC_EN
    chk("bp sayac after", islem_sayisi, cnt_exp);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp pulse ignored", {buyruk_hazir, sonuc_gecerli, mesgul}, 3'b100);
    end

    run("add 15+15", 3'b000, 4'd15, 4'd15, 1, 5'b11110);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
